apical_gain_modulator: RTL and testbench
========================================

# apical_gain_modulator

Consumer-side block for the L1 `apical_gain` signal. It snapshots the Q14 gain and NUM_CH basal (somatic) drive values on each `clk_en`. It then multiplies every channel by the gain on one shared time-multiplexed multiplier, saturates the results and publishes them atomically with a one-cycle valid strobe. It sits between `layer1_minimal` and the pyramidal (L2/3, L5) oscillator inputs, turning apical gain into gated basal drive.

## Interface
- WIDTH, 18, signed fixed-point word width
- FRAC, 14, fractional bits (Q14; 16384 = 1.0)
- NUM_CH, 4, number of basal channels (1..16)
- BURST_GAIN_TH, 20480, gain threshold for burst detection (1.25)
- BURST_DRIVE_TH, 16384, modulated-drive threshold for burst detection (1.0)
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- clk_en  in  1  update strobe (4 kHz-equivalent); starts one modulation pass
- apical_gain  in  WIDTH  signed Q14 gain from L1
- basal_in  in  NUM_CH*WIDTH  signed Q14 drives; channel k at bits [k*WIDTH +: WIDTH]
- modulated_out  out  NUM_CH*WIDTH  signed Q14 gated drives, same packing
- out_valid  out  1  one-cycle pulse when modulated_out updates
- busy  out  1  high while a pass is in progress
- overrun  out  1  sticky; set when clk_en arrives while busy
- burst_flag  out  NUM_CH  per-channel BAC-burst indication

## Operation
- FSM states: IDLE, CAPTURE, MAC, DRAIN, COMMIT.
- IDLE, on clk_en: go to CAPTURE and set busy.
- CAPTURE (1 cycle):
  - Latch apical_gain, clamped to [8192, 24576]. This is defensive; out-of-range gain is not an error.
  - Latch all basal_in words into a snapshot register. Clear the channel counter.
- MAC (NUM_CH cycles): issue one channel per cycle into a 2-stage pipeline.
  - Stage 1: signed WIDTH×WIDTH → 2*WIDTH product, registered.
  - Stage 2: arithmetic shift right by FRAC (truncate toward −inf), saturate to [−2^(WIDTH−1), 2^(WIDTH−1)−1], write into a shadow bank.
- DRAIN (2 cycles): flush the pipeline.
- COMMIT (1 cycle):
  - Copy the shadow bank to modulated_out and burst_flag.
  - Pulse out_valid, clear busy, return to IDLE.
- clk_en while busy: ignored, and overrun is set. The pass in flight is unaffected.
- clk_en in the same cycle as COMMIT also counts as busy: it is ignored and sets overrun.
- Channel counter width: clog2(NUM_CH), minimum 1. It stops at NUM_CH−1 and does not wrap.
- Inputs changing after CAPTURE have no effect on the current pass.

## Timing
- Reset values: modulated_out 0, out_valid 0, busy 0, overrun 0, burst_flag 0, FSM IDLE.
- Latency: clk_en sampled high in IDLE at cycle T gives busy high from T+1 and out_valid at T+NUM_CH+4.
  - NUM_CH=4: out_valid at T+8.
- modulated_out is stable from the commit cycle until the next commit.
- All channels change in the same cycle.
- rst mid-pass: the pass is aborted, no out_valid is issued, and all outputs return to reset values on the next edge.
- overrun is cleared only by rst.

## Configuration
- Macro: `APICAL_BURST_EN`.
- Defined:
  - Stage 2 also computes burst[k] = (clamped gain ≥ BURST_GAIN_TH) && (saturated result ≥ BURST_DRIVE_TH).
  - burst_flag is committed with modulated_out.
- Undefined:
  - burst logic is not built, and burst_flag is tied to 0.
  - The port remains so the interface is identical in both builds.

## Structure
- Shared fixed-point package or include holds the Q14 constants: ONE=16384, HALF=8192, GAIN_1_5=24576, and Q_MAX/Q_MIN for WIDTH. The same constants are used by `layer1_minimal`.
- FSM state encodings are local to this module.
- Sub-module: `q14_mult_sat`, the 2-stage signed multiply, shift and saturate pipeline, reusable elsewhere.

## Test plan
- Reset, gain 16384, basal all 8192, one clk_en → out_valid exactly NUM_CH+4 cycles later; all outputs 8192; busy high for the whole pass.
- Gain 24576, ch0=16384, ch1=−16384 → 24576 and −24576. Gain 8192 → 8192 and −8192.
- Gain 24576, ch0=131071, ch1=−131072 → saturation to 131071 and −131072. Gain 40000 is clamped and gives the same outputs as gain 24576.
- Second clk_en 2 cycles into a pass → ignored; overrun=1 and stays high; exactly one out_valid. basal_in changed mid-pass does not alter the committed results.
- rst asserted at the 3rd MAC cycle → no out_valid; all outputs 0 next cycle. The next clk_en gives a normal pass.
- `APICAL_BURST_EN` defined, gain 20480, ch0=16384, ch1=8192 → burst_flag=0b01. Gain 16384 → 0. Macro undefined → always 0.

Source files
------------

// File: rtl/apical_gain_modulator_pkg.sv
// Shared Q14 fixed-point constants for the apical gain path (also used by layer1_minimal).
package apical_gain_modulator_pkg;

  localparam int Q_WIDTH  = 18;
  localparam int Q_FRAC   = 14;
  localparam int ONE      = 16384;
  localparam int HALF     = 8192;
  localparam int GAIN_1_5 = 24576;
  localparam int Q_MAX    = (2 ** (Q_WIDTH - 1)) - 1;
  localparam int Q_MIN    = -(2 ** (Q_WIDTH - 1));

endpackage

// File: rtl/q14_mult_sat.sv
// Two-stage signed multiply / arithmetic shift / saturate pipeline: the product is
// registered here, and the shifted, saturated word is meant to be registered by the consumer.
module q14_mult_sat
  import apical_gain_modulator_pkg::*;
#(
  parameter int WIDTH = Q_WIDTH,
  parameter int FRAC  = Q_FRAC,
  parameter int TAG_W = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [TAG_W-1:0]        in_tag,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic                    out_valid,
  output logic [TAG_W-1:0]        out_tag,
  output logic signed [WIDTH-1:0] result
);

  localparam logic signed [2*WIDTH-1:0] SAT_MAX = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [2*WIDTH-1:0] SAT_MIN = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  logic signed [2*WIDTH-1:0] a_ext;
  logic signed [2*WIDTH-1:0] b_ext;
  logic signed [2*WIDTH-1:0] prod_q;
  logic signed [2*WIDTH-1:0] shifted;

  assign a_ext = {{WIDTH{a[WIDTH-1]}}, a};
  assign b_ext = {{WIDTH{b[WIDTH-1]}}, b};

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q    <= '0;
      out_valid <= 1'b0;
      out_tag   <= '0;
    end else begin
      prod_q    <= a_ext * b_ext;
      out_valid <= in_valid;
      out_tag   <= in_tag;
    end
  end

  // Arithmetic shift floors toward -inf before clamping into the WIDTH-bit range.
  assign shifted = prod_q >>> FRAC;

  always_comb begin
    result = shifted[WIDTH-1:0];
    if (shifted > SAT_MAX) begin
      result = SAT_MAX[WIDTH-1:0];
    end else if (shifted < SAT_MIN) begin
      result = SAT_MIN[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/apical_gain_modulator.sv
// Gates NUM_CH basal drives by the clamped apical gain on one shared multiplier and commits atomically.
// Optional BAC-burst detection is built when APICAL_BURST_EN is defined.
module apical_gain_modulator
  import apical_gain_modulator_pkg::*;
#(
  parameter int WIDTH          = Q_WIDTH,
  parameter int FRAC           = Q_FRAC,
  parameter int NUM_CH         = 4,
  parameter int BURST_GAIN_TH  = 20480,
  parameter int BURST_DRIVE_TH = ONE
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clk_en,
  input  logic signed [WIDTH-1:0]   apical_gain,
  input  logic [NUM_CH*WIDTH-1:0]   basal_in,
  output logic [NUM_CH*WIDTH-1:0]   modulated_out,
  output logic                      out_valid,
  output logic                      busy,
  output logic                      overrun,
  output logic [NUM_CH-1:0]         burst_flag
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] CAPTURE = 3'd1;
  localparam logic [2:0] MAC     = 3'd2;
  localparam logic [2:0] DRAIN   = 3'd3;
  localparam logic [2:0] COMMIT  = 3'd4;

  localparam logic signed [WIDTH-1:0] GAIN_LO = WIDTH'(HALF);
  localparam logic signed [WIDTH-1:0] GAIN_HI = WIDTH'(GAIN_1_5);

  logic [2:0]                state;
  logic [CW-1:0]             cnt;
  logic                      drain_cnt;
  logic signed [WIDTH-1:0]   gain_q;
  logic signed [WIDTH-1:0]   gain_clamped;
  logic signed [WIDTH-1:0]   mac_b;
  logic [NUM_CH*WIDTH-1:0]   snap_q;
  logic [NUM_CH*WIDTH-1:0]   shadow_q;
  logic [NUM_CH*WIDTH-1:0]   mod_q;
  logic                      overrun_q;
  logic                      mul_valid;
  logic [CW-1:0]             mul_tag;
  logic signed [WIDTH-1:0]   mul_result;
  logic                      commit_now;

  always_comb begin
    gain_clamped = apical_gain;
    if (apical_gain < GAIN_LO) begin
      gain_clamped = GAIN_LO;
    end else if (apical_gain > GAIN_HI) begin
      gain_clamped = GAIN_HI;
    end
  end

  assign mac_b      = snap_q[int'(cnt)*WIDTH +: WIDTH];
  assign commit_now = (state == DRAIN) && drain_cnt;

  q14_mult_sat #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC),
    .TAG_W (CW)
  ) u_mult (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (state == MAC),
    .in_tag    (cnt),
    .a         (gain_q),
    .b         (mac_b),
    .out_valid (mul_valid),
    .out_tag   (mul_tag),
    .result    (mul_result)
  );

  // Outputs are loaded on the edge into COMMIT so they are visible during the out_valid cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      drain_cnt <= 1'b0;
      gain_q    <= '0;
      snap_q    <= '0;
      shadow_q  <= '0;
      mod_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (clk_en && (state != IDLE)) begin
        overrun_q <= 1'b1;
      end
      if (mul_valid) begin
        shadow_q[int'(mul_tag)*WIDTH +: WIDTH] <= mul_result;
      end
      case (state)
        IDLE: begin
          if (clk_en) state <= CAPTURE;
        end
        CAPTURE: begin
          gain_q <= gain_clamped;
          snap_q <= basal_in;
          cnt    <= '0;
          state  <= MAC;
        end
        MAC: begin
          if (cnt == CW'(NUM_CH - 1)) begin
            drain_cnt <= 1'b0;
            state     <= DRAIN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (drain_cnt) begin
            mod_q <= shadow_q;
            state <= COMMIT;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        COMMIT:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign modulated_out = mod_q;
  assign out_valid     = (state == COMMIT);
  assign busy          = (state != IDLE);
  assign overrun       = overrun_q;

`ifdef APICAL_BURST_EN
  localparam logic signed [WIDTH-1:0] GAIN_TH  = WIDTH'(BURST_GAIN_TH);
  localparam logic signed [WIDTH-1:0] DRIVE_TH = WIDTH'(BURST_DRIVE_TH);

  logic [NUM_CH-1:0] burst_shadow_q;
  logic [NUM_CH-1:0] burst_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      burst_shadow_q <= '0;
      burst_q        <= '0;
    end else begin
      if (mul_valid) begin
        burst_shadow_q[mul_tag] <= (gain_q >= GAIN_TH) && (mul_result >= DRIVE_TH);
      end
      if (commit_now) begin
        burst_q <= burst_shadow_q;
      end
    end
  end

  assign burst_flag = burst_q;
`else
  logic unused_burst_cfg;
  assign unused_burst_cfg = ^{32'(BURST_GAIN_TH), 32'(BURST_DRIVE_TH), commit_now};
  assign burst_flag = '0;
`endif

endmodule

// File: tb/tb_apical_gain_modulator.sv
// Scoreboard bench for apical_gain_modulator: expected commits are queued at each clk_en and
// popped by a monitor when out_valid fires; scenario tasks add latency/flag/boundary checks.
module tb_apical_gain_modulator;

  localparam int W   = 18;
  localparam int NCH = 4;

  typedef struct packed {
    logic [NCH*W-1:0] mod;
    logic [NCH-1:0]   burst;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  clk_en;
  logic signed [W-1:0]   apical_gain;
  logic [NCH*W-1:0]      basal_in;
  logic [NCH*W-1:0]      modulated_out;
  logic                  out_valid;
  logic                  busy;
  logic                  overrun;
  logic [NCH-1:0]        burst_flag;

  int   total = 0;
  int   bad   = 0;
  int   gain_v;
  int   basal_v [NCH];
  exp_t sb [$];

  always #5 clk = ~clk;

  apical_gain_modulator #(
    .WIDTH          (W),
    .FRAC           (14),
    .NUM_CH         (NCH),
    .BURST_GAIN_TH  (20480),
    .BURST_DRIVE_TH (16384)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .clk_en        (clk_en),
    .apical_gain   (apical_gain),
    .basal_in      (basal_in),
    .modulated_out (modulated_out),
    .out_valid     (out_valid),
    .busy          (busy),
    .overrun       (overrun),
    .burst_flag    (burst_flag)
  );

  function automatic int clamp_gain(int g);
    if (g < 8192)  return 8192;
    if (g > 24576) return 24576;
    return g;
  endfunction

  function automatic int model_ch(int g, int b);
    longint p;
    longint s;
    p = longint'(clamp_gain(g)) * longint'(b);
    s = p >>> 14;
    if (s > 131071)       s = 131071;
    else if (s < -131072) s = -131072;
    return int'(s);
  endfunction

  function automatic exp_t build_exp();
    exp_t e;
    int   m;
    e = '0;
    for (int k = 0; k < NCH; k++) begin
      m = model_ch(gain_v, basal_v[k]);
      e.mod[k*W +: W] = W'(m);
`ifdef APICAL_BURST_EN
      e.burst[k] = (clamp_gain(gain_v) >= 20480) && (m >= 16384);
`else
      e.burst[k] = 1'b0;
`endif
    end
    return e;
  endfunction

  function automatic int ch(int k);
    logic signed [W-1:0] t;
    t = modulated_out[k*W +: W];
    return int'(t);
  endfunction

  // Scoreboard monitor: every out_valid must match the oldest queued expectation.
  always @(negedge clk) begin
    if (out_valid) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("[TB] FAIL unexpected_valid: got out_valid=1 want no commit pending");
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (modulated_out !== e.mod) begin
          bad++;
          $display("[TB] FAIL sb_modulated_out: got %h want %h", modulated_out, e.mod);
        end
        total++;
        if (burst_flag !== e.burst) begin
          bad++;
          $display("[TB] FAIL sb_burst_flag: got %b want %b", burst_flag, e.burst);
        end
      end
    end
  end

  task automatic apply_inputs();
    apical_gain = W'(gain_v);
    for (int k = 0; k < NCH; k++) basal_in[k*W +: W] = W'(basal_v[k]);
  endtask

  task automatic set_vec(int g, int b0, int b1, int b2, int b3);
    gain_v = g;
    basal_v[0] = b0; basal_v[1] = b1; basal_v[2] = b2; basal_v[3] = b3;
    apply_inputs();
  endtask

  // Called at a negedge; returns one negedge later with clk_en dropped.
  task automatic start_pass();
    apply_inputs();
    clk_en = 1'b1;
    sb.push_back(build_exp());
    @(negedge clk);
    clk_en = 1'b0;
  endtask

  // Waits (bounded) for out_valid; lat counts negedges from the clk_en cycle, -1 on timeout.
  task automatic wait_valid(output int lat, output bit busy_ok);
    lat = -1;
    busy_ok = 1'b1;
    for (int k = 1; k < 60; k++) begin
      if (!busy) busy_ok = 1'b0;
      if (out_valid) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clk_en = 1'b0;
    set_vec(16384, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    total++;
    if (modulated_out !== '0 || out_valid !== 1'b0 || busy !== 1'b0 ||
        overrun !== 1'b0 || burst_flag !== '0) begin
      bad++;
      $display("[TB] FAIL reset_state: got mod=%h v=%b b=%b o=%b bf=%b want all zero",
               modulated_out, out_valid, busy, overrun, burst_flag);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_unity();
    int lat;
    bit bok;
    set_vec(16384, 8192, 8192, 8192, 8192);
    start_pass();
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL busy_rise: got %b want 1", busy);
    end
    wait_valid(lat, bok);
    total++;
    if (lat !== NCH + 4) begin
      bad++;
      $display("[TB] FAIL latency: got %0d want %0d", lat, NCH + 4);
    end
    total++;
    if (bok !== 1'b1) begin
      bad++;
      $display("[TB] FAIL busy_hold: got busy dropped mid-pass want held");
    end
    for (int k = 0; k < NCH; k++) begin
      total++;
      if (ch(k) !== 8192) begin
        bad++;
        $display("[TB] FAIL unity_ch%0d: got %0d want 8192", k, ch(k));
      end
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL after_commit: got v=%b busy=%b want 0 0", out_valid, busy);
    end
  endtask

  task automatic test_gain_scaling();
    int lat;
    bit bok;
    set_vec(24576, 16384, -16384, 1000, -3);
    start_pass();
    wait_valid(lat, bok);
    total++;
    if (ch(0) !== 24576 || ch(1) !== -24576 || ch(3) !== -5) begin
      bad++;
      $display("[TB] FAIL gain_1_5: got %0d %0d %0d want 24576 -24576 -5", ch(0), ch(1), ch(3));
    end
    @(negedge clk);
    set_vec(8192, 16384, -16384, 1000, -3);
    start_pass();
    wait_valid(lat, bok);
    total++;
    if (ch(0) !== 8192 || ch(1) !== -8192 || ch(3) !== -2) begin
      bad++;
      $display("[TB] FAIL gain_0_5: got %0d %0d %0d want 8192 -8192 -2", ch(0), ch(1), ch(3));
    end
    @(negedge clk);
  endtask

  task automatic test_saturation();
    int lat;
    bit bok;
    int gains [3] = '{24576, 40000, -5000};
    int want0 [3] = '{131071, 131071, 65535};
    int want1 [3] = '{-131072, -131072, -65536};
    for (int i = 0; i < 3; i++) begin
      set_vec(gains[i], 131071, -131072, 5, 0);
      start_pass();
      wait_valid(lat, bok);
      total++;
      if (ch(0) !== want0[i] || ch(1) !== want1[i]) begin
        bad++;
        $display("[TB] FAIL saturate_g%0d: got %0d %0d want %0d %0d",
                 gains[i], ch(0), ch(1), want0[i], want1[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_overrun();
    int nvalid = 0;
    set_vec(16384, 100, 200, 300, 400);
    start_pass();
    @(negedge clk);
    basal_v[0] = 9999; basal_v[1] = -9999;
    apical_gain = W'(24576);
    basal_in[0 +: W] = W'(9999);
    basal_in[W +: W] = W'(-9999);
    clk_en = 1'b1;
    @(negedge clk);
    clk_en = 1'b0;
    total++;
    if (overrun !== 1'b1) begin
      bad++;
      $display("[TB] FAIL overrun_set: got %b want 1", overrun);
    end
    for (int k = 0; k < 20; k++) begin
      if (out_valid) nvalid++;
      @(negedge clk);
    end
    total++;
    if (nvalid !== 1) begin
      bad++;
      $display("[TB] FAIL overrun_single_commit: got %0d valids want 1", nvalid);
    end
    total++;
    if (overrun !== 1'b1 || ch(0) !== 100) begin
      bad++;
      $display("[TB] FAIL overrun_sticky: got o=%b ch0=%0d want 1 100", overrun, ch(0));
    end
  endtask

  task automatic test_reset_mid_pass();
    int nvalid = 0;
    int lat;
    bit bok;
    set_vec(20000, 4000, 4000, 4000, 4000);
    start_pass();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    void'(sb.pop_back());
    @(negedge clk);
    total++;
    if (modulated_out !== '0 || out_valid !== 1'b0 || busy !== 1'b0 ||
        overrun !== 1'b0 || burst_flag !== '0) begin
      bad++;
      $display("[TB] FAIL midpass_reset: got mod=%h v=%b b=%b o=%b want zeros",
               modulated_out, out_valid, busy, overrun);
    end
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (out_valid) nvalid++;
      @(negedge clk);
    end
    total++;
    if (nvalid !== 0) begin
      bad++;
      $display("[TB] FAIL aborted_valid: got %0d valids want 0", nvalid);
    end
    set_vec(16384, 1234, -1234, 0, 77);
    start_pass();
    wait_valid(lat, bok);
    total++;
    if (lat !== NCH + 4 || ch(0) !== 1234) begin
      bad++;
      $display("[TB] FAIL post_reset_pass: got lat=%0d ch0=%0d want %0d 1234", lat, ch(0), NCH + 4);
    end
    @(negedge clk);
  endtask

  task automatic test_burst();
    int lat;
    bit bok;
    logic [NCH-1:0] want;
`ifdef APICAL_BURST_EN
    want = 4'b0001;
`else
    want = 4'b0000;
`endif
    set_vec(20480, 16384, 8192, 0, 0);
    start_pass();
    wait_valid(lat, bok);
    total++;
    if (burst_flag !== want) begin
      bad++;
      $display("[TB] FAIL burst_high_gain: got %b want %b", burst_flag, want);
    end
    @(negedge clk);
    set_vec(16384, 16384, 8192, 0, 0);
    start_pass();
    wait_valid(lat, bok);
    total++;
    if (burst_flag !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL burst_unity_gain: got %b want 0000", burst_flag);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat;
    bit bok;
    for (int i = 0; i < 4; i++) begin
      gain_v = int'($urandom_range(0, 45000));
      for (int k = 0; k < NCH; k++) basal_v[k] = int'($urandom_range(0, 262143)) - 131072;
      start_pass();
      wait_valid(lat, bok);
      total++;
      if (lat !== NCH + 4) begin
        bad++;
        $display("[TB] FAIL b2b_latency%0d: got %0d want %0d", i, lat, NCH + 4);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    clk_en = 1'b0;
    apical_gain = '0;
    basal_in = '0;
    @(negedge clk);
    test_reset();
    test_unity();
    test_gain_scaling();
    test_saturation();
    test_burst();
    test_overrun();
    test_reset_mid_pass();
    test_back_to_back();
    repeat (3) @(negedge clk);
    total++;
    if (sb.size() !== 0) begin
      bad++;
      $display("[TB] FAIL sb_drain: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
